// File: rtl/sipo_pkg.sv
// sipo_pkg: shared constants and helpers for the sipo deserializer (default width, bit-counter width)
package sipo_pkg;
  localparam int SIPO_DEF_WIDTH = 10;
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/sipo_bit_cnt.sv
// sipo_bit_cnt: free-running bit counter 0..term with sync active-low reset; wrap is high while the count equals term
module sipo_bit_cnt
  import sipo_pkg::*;
#(
  parameter int W = cnt_width(SIPO_DEF_WIDTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] term,
  output logic         wrap
);
  logic [W-1:0] cnt;
  assign wrap = cnt == term;
  always_ff @(posedge clk)
    cnt <= (!reset || wrap) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sipo.sv
// sipo: serial-in parallel-out shifter (clk, reset sync active-low, s_in -> parallel_out[WIDTH], word_valid strobe); framing built only with SIPO_WORD_VALID_EN
module sipo
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_DEF_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             word_valid
);
  localparam int CW = cnt_width(WIDTH);
  always_ff @(posedge clk)
    parallel_out <= !reset ? '0 :
                    (MSB_FIRST != 0) ? {parallel_out[WIDTH-2:0], s_in} : {s_in, parallel_out[WIDTH-1:1]};
`ifdef SIPO_WORD_VALID_EN
  logic wrap;
  sipo_bit_cnt #(.W(CW)) u_bit_cnt (
    .clk  (clk),
    .reset(reset),
    .term (CW'(WIDTH - 1)),
    .wrap (wrap)
  );
  always_ff @(posedge clk)
    word_valid <= reset && wrap;
`else
  assign word_valid = 1'b0;
`endif
endmodule

// File: tb/tb_sipo.sv
// tb_sipo: directed scoreboard bench for sipo, MSB-first and LSB-first instances driven from one serial stream
module tb_sipo;
  import sipo_pkg::*;
  localparam int W = SIPO_DEF_WIDTH;
`ifdef SIPO_WORD_VALID_EN
  localparam bit WV_EN = 1'b1;
`else
  localparam bit WV_EN = 1'b0;
`endif
  typedef struct packed {
    logic [W-1:0] m;
    logic [W-1:0] l;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s_in = 1'b0;
  logic [W-1:0] po_m, po_l;
  logic wv_m, wv_l;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int bits = 0;
  always #5 clk = ~clk;
  sipo #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .s_in(s_in), .parallel_out(po_m), .word_valid(wv_m)
  );
  sipo #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .s_in(s_in), .parallel_out(po_l), .word_valid(wv_l)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic b);
    exp_t e;
    s_in = b;
    @(posedge clk);
    #1;
    bits++;
    chk("word_valid_m", 64'(wv_m), 64'(WV_EN && (bits % W == 0)));
    chk("word_valid_l", 64'(wv_l), 64'(WV_EN && (bits % W == 0)));
    if (bits % W == 0) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("word_m", 64'(po_m), 64'(e.m));
        chk("word_l", 64'(po_l), 64'(e.l));
      end
    end
  endtask
  task automatic hold_reset(input int n);
    reset = 1'b0;
    repeat (n) begin
      s_in = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_po_m", 64'(po_m), 64'd0);
      chk("rst_po_l", 64'(po_l), 64'd0);
      chk("rst_wv_m", 64'(wv_m), 64'd0);
      chk("rst_wv_l", 64'(wv_l), 64'd0);
    end
    bits = 0;
    reset = 1'b1;
  endtask
  task automatic send(input logic [W-1:0] seq, input logic [W-1:0] m, input logic [W-1:0] l);
    exp_t e;
    e.m = m;
    e.l = l;
    sb.push_back(e);
    for (int i = 0; i < W; i++) step(seq[i]);
  endtask
  task automatic send_rand();
    logic [W-1:0] seq, m;
    seq = W'($urandom);
    for (int i = 0; i < W; i++) m[W-1-i] = seq[i];
    send(seq, m, seq);
  endtask
  initial begin
    hold_reset(10);
    send({W{1'b1}}, 10'h3FF, 10'h3FF);
    send(10'b1111100111, 10'b1110011111, 10'b1111100111);
    repeat (3) send_rand();
    hold_reset(2);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    chk("partial_m", 64'(po_m), 64'h00B);
    chk("partial_l", 64'(po_l), 64'h340);
    hold_reset(1);
    send_rand();
    send(10'b0000000001, 10'b1000000000, 10'b0000000001);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sipo.md
SIPO -- requirements
Module: sipo

Interface
REQ-001 Parameter WIDTH, default 10: parallel word width in bits, legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first received bit ends up in bit WIDTH-1; 0 means it ends up in bit 0.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-low.
REQ-005 Port s_in, input, 1 bit: serial data, sampled on every rising clk edge while not in reset.
REQ-006 Port parallel_out, output, WIDTH bits: registered shift-register contents.
REQ-007 Port word_valid, output, 1 bit: one-cycle strobe marking that a full WIDTH-bit word has been shifted in.

Function
REQ-008 The shift register SHALL shift on every rising clk edge when reset is deasserted; there is no enable and no stall.
- MSB_FIRST=1: parallel_out <= {parallel_out[WIDTH-2:0], s_in}.
- MSB_FIRST=0: parallel_out <= {s_in, parallel_out[WIDTH-1:1]}.
REQ-009 Latency SHALL be one cycle: a bit sampled at edge N is visible on parallel_out after edge N.
REQ-010 parallel_out SHALL continuously show the last WIDTH sampled bits; it is not held between words.
REQ-011 A bit counter SHALL count 0..WIDTH-1 and wrap to 0 on the edge that samples the WIDTH-th bit of a word.
REQ-012 word_valid SHALL be high for exactly the one cycle following the edge that samples the WIDTH-th bit.
REQ-013 When word_valid is high, parallel_out SHALL hold that complete word.
REQ-014 Words SHALL be back-to-back: word_valid pulses every WIDTH cycles after reset release, with no idle gap.
REQ-015 s_in SHALL have no effect while reset is asserted.

Reset
REQ-016 While reset is sampled low at a rising edge, the block SHALL set parallel_out to 0, the bit counter to 0 and word_valid to 0.
REQ-017 Reset asserted mid-word SHALL discard the partial word; counting restarts at the first edge with reset high.
REQ-018 The block SHALL have no asynchronous reset path.

Configuration
REQ-019 The macro SIPO_WORD_VALID_EN SHALL control the word-framing feature.
- Defined: the bit counter and word_valid logic are compiled in, as in REQ-011..REQ-014.
- Undefined: no counter is built and word_valid is tied to 0; the port list is unchanged.

Structure
REQ-020 A shared package sipo_pkg SHALL hold:
- the default width constant, SIPO_DEF_WIDTH = 10;
- a function returning the bit-counter width, $clog2(WIDTH).
REQ-021 The bit counter SHALL be a sub-module, sipo_bit_cnt, with inputs clk, reset and a terminal count, and a wrap output.
REQ-022 sipo_bit_cnt SHALL be instantiated only when SIPO_WORD_VALID_EN is defined.

Verification
REQ-023 Hold reset low for 10 cycles with s_in=1 -> parallel_out=10'h000 and word_valid=0 throughout.
REQ-024 Release reset, then drive 10 ones -> parallel_out=10'h3FF after the 10th edge, with word_valid high for that one cycle (macro defined).
REQ-025 Drive serial pattern 1,1,1,0,0,1,1,1,1,1, with MSB_FIRST=1 -> parallel_out=10'b1110011111 when word_valid pulses.
- With MSB_FIRST=0, the same pattern -> parallel_out=10'b1111100111.
REQ-026 Stream 30 continuous bits -> word_valid pulses at cycles 10, 20 and 30 after reset release, and is low at every other cycle.
REQ-027 Assert reset after 4 bits of a word, then release -> parallel_out=0 and the next word_valid occurs 10 cycles after release.
REQ-028 Build without SIPO_WORD_VALID_EN and run REQ-024 -> parallel_out=10'h3FF and word_valid stays 0.
